// File: rtl/lfsr_bist_ctrl.sv
// BIST sequencer for a 4-bit feedback LFSR: serially loads a seed, runs the
// LFSR for run_len feedback cycles, captures the result and compares it with
// a golden signature. Drives the LFSR en/serial_in and observes its shift_reg.
module lfsr_bist_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] run_len,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] lfsr_q,
  output logic             lfsr_en,
  output logic             lfsr_serial,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic             err_zero_seed
);

  localparam int unsigned LCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_CHECK = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic [WIDTH-1:0]  sh_q,       sh_d;
  logic [CNT_W-1:0]  run_len_q,  run_len_d;
  logic [WIDTH-1:0]  exp_q,      exp_d;
  logic [LCNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]  run_cnt_q,  run_cnt_d;
  logic              en_d;
  logic              serial_d;
  logic              busy_d;
  logic              done_d;
  logic              pass_d;
  logic [WIDTH-1:0]  sig_d;
  logic              err_d;

  // State, latched operands, counters and all outputs registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sh_q          <= '0;
      run_len_q     <= '0;
      exp_q         <= '0;
      load_cnt_q    <= '0;
      run_cnt_q     <= '0;
      lfsr_en       <= 1'b0;
      lfsr_serial   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      signature     <= '0;
      err_zero_seed <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      run_len_q     <= run_len_d;
      exp_q         <= exp_d;
      load_cnt_q    <= load_cnt_d;
      run_cnt_q     <= run_cnt_d;
      lfsr_en       <= en_d;
      lfsr_serial   <= serial_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      signature     <= sig_d;
      err_zero_seed <= err_d;
    end
  end

  // Next-state and next-output logic; outputs are the values for the coming cycle
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    run_len_d  = run_len_q;
    exp_d      = exp_q;
    load_cnt_d = load_cnt_q;
    run_cnt_d  = run_cnt_q;
    en_d       = 1'b0;
    serial_d   = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    sig_d      = signature;
    err_d      = err_zero_seed;

    if (abort) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      pass_d     = 1'b0;
      load_cnt_d = '0;
      run_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sh_d       = {seed[WIDTH-2:0], 1'b0};
            run_len_d  = run_len;
            exp_d      = expected;
            pass_d     = 1'b0;
            load_cnt_d = '0;
            if (seed == '0) begin
              // an all-zero LFSR never leaves zero: report instead of running
              err_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              err_d    = 1'b0;
              state_d  = S_LOAD;
              busy_d   = 1'b1;
              serial_d = seed[WIDTH-1];
            end
          end
        end

        S_LOAD: begin
          if (load_cnt_q == LCNT_W'(WIDTH - 1)) begin
            if (run_len_q != '0) begin
              state_d   = S_RUN;
              run_cnt_d = run_len_q;
              en_d      = 1'b1;
            end else begin
              state_d = S_CHECK;
            end
          end else begin
            load_cnt_d = load_cnt_q + LCNT_W'(1);
            serial_d   = sh_q[WIDTH-1];
            sh_d       = {sh_q[WIDTH-2:0], 1'b0};
          end
        end

        S_RUN: begin
          if (run_cnt_q <= CNT_W'(1)) begin
            state_d   = S_CHECK;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q - CNT_W'(1);
            en_d      = 1'b1;
          end
        end

        S_CHECK: begin
          sig_d   = lfsr_q;
          pass_d  = (lfsr_q == exp_q);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Scoreboard bench for lfsr_bist_ctrl with a behavioural 4-bit LFSR attached.
module tb_lfsr_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] seed;
  logic [7:0] run_len;
  logic [3:0] expected;
  logic [3:0] lfsr_q = 4'b0000;
  logic       lfsr_en;
  logic       lfsr_serial;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] signature;
  logic       err_zero_seed;

  typedef struct {
    int         cyc;
    logic [3:0] sig;
    logic       pass;
    logic       err;
    int         busy;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         brun = 0;
  logic [3:0] last_sig = 4'b0000;

  lfsr_bist_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .seed          (seed),
    .run_len       (run_len),
    .expected      (expected),
    .lfsr_q        (lfsr_q),
    .lfsr_en       (lfsr_en),
    .lfsr_serial   (lfsr_serial),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .signature     (signature),
    .err_zero_seed (err_zero_seed)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  // Attached LFSR: shift left, feedback q[3]^q[0] when en, else serial_in
  always @(posedge clk)
    lfsr_q <= {lfsr_q[2:0], lfsr_en ? (lfsr_q[3] ^ lfsr_q[0]) : lfsr_serial};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: on every done pulse pop the oldest expectation and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) begin
        brun++;
      end else begin
        if (done) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
          end else begin
            e = sbq.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("signature", 32'(signature), 32'(e.sig));
            chk("pass", 32'(pass), 32'(e.pass));
            chk("err_zero_seed", 32'(err_zero_seed), 32'(e.err));
            chk("busy_span", 32'(brun), 32'(e.busy));
          end
        end
        brun = 0;
      end
    end
  end

  // Issue one start (called at a negedge) and queue its expected outcome
  task automatic run_pass(input logic [3:0] s, input logic [7:0] rl, input logic [3:0] ex,
                          input logic [3:0] es, input logic ep, input logic ee);
    exp_t e;
    int   lat;
    lat      = (s == 4'd0) ? 0 : (4 + int'(rl) + 1);
    seed     = s;
    run_len  = rl;
    expected = ex;
    start    = 1'b1;
    e.cyc    = cyc + 1 + lat;
    e.sig    = es;
    e.pass   = ep;
    e.err    = ee;
    e.busy   = (s == 4'd0) ? 0 : lat;
    sbq.push_back(e);
    if (s != 4'd0) last_sig = es;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=pending expected=none (t=%0t)", $time);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout actual=0 expected=1 (t=%0t)", $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lfsr_en"}, 32'(lfsr_en), 0);
    chk({tag, "_lfsr_serial"}, 32'(lfsr_serial), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_signature"}, 32'(signature), 0);
    chk({tag, "_err_zero_seed"}, 32'(err_zero_seed), 0);
  endtask

  initial begin
    logic [3:0] sv;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    seed     = 4'd0;
    run_len  = 8'd0;
    expected = 4'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // seed 0001, 4 feedback cycles -> 1110; serial MSB first, en during RUN
    sv = 4'b0001;
    run_pass(4'b0001, 8'd4, 4'b1110, 4'b1110, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      chk("load_serial", 32'(lfsr_serial), 32'(sv[3-k]));
      chk("load_en", 32'(lfsr_en), 0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("run_en", 32'(lfsr_en), 1);
    end
    wait_idle();

    // Full period wraps back to the seed; back-to-back start in the done cycle
    run_pass(4'b0001, 8'd15, 4'b0001, 4'b0001, 1'b1, 1'b0);
    wait_done();
    run_pass(4'b0001, 8'd15, 4'b0011, 4'b0001, 1'b0, 1'b0);
    wait_idle();

    // Zero seed: immediate done with error, never busy, LFSR never in feedback
    run_pass(4'b0000, 8'd7, 4'b0000, last_sig, 1'b0, 1'b1);
    chk("zero_seed_busy", 32'(busy), 0);
    chk("zero_seed_en", 32'(lfsr_en), 0);
    @(negedge clk);
    chk("zero_seed_busy2", 32'(busy), 0);
    chk("zero_seed_en2", 32'(lfsr_en), 0);
    wait_idle();

    // run_len 0: signature is the loaded seed
    run_pass(4'b1010, 8'd0, 4'b1010, 4'b1010, 1'b1, 1'b0);
    wait_idle();
    run_pass(4'b1010, 8'd0, 4'b0101, 4'b1010, 1'b0, 1'b0);
    wait_idle();

    // Single feedback cycle: 1000 -> 0001
    run_pass(4'b1000, 8'd1, 4'b0001, 4'b0001, 1'b1, 1'b0);
    wait_idle();

    // start pulsed during RUN is ignored
    run_pass(4'b0001, 8'd15, 4'b0001, 4'b0001, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    seed    = 4'b1010;
    run_len = 8'd0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_busy", 32'(busy), 1);
    wait_idle();

    // abort in RUN with a simultaneous start: idle, no done, signature kept
    seed     = 4'b0001;
    run_len  = 8'd15;
    expected = 4'b0001;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pass", 32'(pass), 0);
    chk("abort_en", 32'(lfsr_en), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_signature", 32'(signature), 32'(last_sig));
    @(negedge clk);
    chk("abort_start_rejected", 32'(busy), 0);
    repeat (25) @(negedge clk);

    // Reset mid-LOAD clears outputs at once; a fresh pass then runs cleanly
    seed    = 4'b0001;
    run_len = 8'd4;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_pass(4'b0001, 8'd4, 4'b1110, 4'b1110, 1'b1, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule
